// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, fflags bit positions,
// canonical NaN and the FDIV sequencer state type.
package fpu_pkg;

    localparam int DIV_WIDTH = 27;
    localparam int EXP_BIAS  = 127;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_WAIT,
        ST_ROUND,
        ST_DONE
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_round.sv
// Combinational round-and-pack stage for binary32 results (shared with fsqrt).
// Takes a normalized 24-bit significand with guard/sticky and a biased exponent.
module fdiv_round
    import fpu_pkg::*;
(
    input  logic              i_sign,
    input  logic [23:0]       i_sig,
    input  logic              i_g,
    input  logic              i_s,
    input  logic signed [9:0] i_exp,
    input  logic [2:0]        i_rm,
    output logic [31:0]       o_result,
    output logic [4:0]        o_fflags
);

    logic              w_inexact;
    logic              w_up;
    logic              w_ovf_inf;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp;
    logic              w_unused_sum;

    assign w_unused_sum = w_sum[23];

    // Unknown rounding modes fall through to the RNE default arms.
    always_comb begin
        w_inexact = i_g | i_s;
        case (i_rm)
            RM_RTZ:  w_up = 1'b0;
            RM_RDN:  w_up = i_sign & w_inexact;
            RM_RUP:  w_up = ~i_sign & w_inexact;
            RM_RMM:  w_up = i_g;
            default: w_up = i_g & (i_s | i_sig[0]);
        endcase

        w_sum = {1'b0, i_sig} + {24'b0, w_up};
        w_exp = w_sum[24] ? (i_exp + 10'sd1) : i_exp;

        case (i_rm)
            RM_RTZ:  w_ovf_inf = 1'b0;
            RM_RDN:  w_ovf_inf = i_sign;
            RM_RUP:  w_ovf_inf = ~i_sign;
            default: w_ovf_inf = 1'b1;
        endcase

        o_fflags = 5'b0;
        if (w_exp >= 10'sd255) begin
            o_fflags[FF_OF] = 1'b1;
            o_fflags[FF_NX] = 1'b1;
            o_result = w_ovf_inf ? {i_sign, 8'hFF, 23'h000000}
                                 : {i_sign, 8'hFE, 23'h7FFFFF};
        end else if (w_exp <= 10'sd0) begin
            o_fflags[FF_UF] = 1'b1;
            o_fflags[FF_NX] = 1'b1;
            o_result = {i_sign, 31'h0};
        end else begin
            // On carry-out the low bits are already zero, giving 1.0 x 2^(e+1).
            o_fflags[FF_NX] = w_inexact;
            o_result = {i_sign, w_exp[7:0], w_sum[22:0]};
        end
    end

endmodule

// File: rtl/fdiv_ctrl.sv
// FDIV.S sequencer: unpacks operands, resolves special cases, drives an external
// free-running SRT divider, then normalizes/rounds/packs the quotient.
module fdiv_ctrl
    import fpu_pkg::*;
#(
    parameter int DIV_WIDTH = fpu_pkg::DIV_WIDTH,
    parameter int EXP_BIAS  = fpu_pkg::EXP_BIAS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [31:0]          i_op_a,
    input  logic [31:0]          i_op_b,
    input  logic [2:0]           i_rm,
    output logic [DIV_WIDTH-1:0] o_div_dividend,
    output logic [DIV_WIDTH-1:0] o_div_divisor,
    input  logic [DIV_WIDTH:0]   i_div_quotient,
    input  logic                 i_div_valid,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [31:0]          o_result,
    output logic [4:0]           o_fflags
);

    fdiv_state_t          r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [31:0]          r_result;
    logic [4:0]           r_fflags;
    logic [DIV_WIDTH-1:0] r_div_dividend;
    logic [DIV_WIDTH-1:0] r_div_divisor;
    logic [DIV_WIDTH-1:0] r_q;
    logic                 r_sign;
    logic [7:0]           r_ea;
    logic [7:0]           r_eb;
    logic [2:0]           r_rm;

    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic              w_sign;
    logic              w_special;
    logic [31:0]       w_spec_result;
    logic [4:0]        w_spec_flags;
    logic [23:0]       w_sig;
    logic              w_g;
    logic              w_s;
    logic signed [9:0] w_exp;
    logic [31:0]       w_rnd_result;
    logic [4:0]        w_rnd_flags;
    logic              w_unused_qmsb;

    assign w_unused_qmsb = i_div_quotient[DIV_WIDTH];

    // Subnormal operands (exponent 0) are flushed and treated as zero.
    always_comb begin
        w_sign   = i_op_a[31] ^ i_op_b[31];
        w_a_zero = (i_op_a[30:23] == 8'h00);
        w_b_zero = (i_op_b[30:23] == 8'h00);
        w_a_inf  = (i_op_a[30:23] == 8'hFF) && (i_op_a[22:0] == 23'h0);
        w_b_inf  = (i_op_b[30:23] == 8'hFF) && (i_op_b[22:0] == 23'h0);
        w_a_nan  = (i_op_a[30:23] == 8'hFF) && (i_op_a[22:0] != 23'h0);
        w_b_nan  = (i_op_b[30:23] == 8'hFF) && (i_op_b[22:0] != 23'h0);
        w_a_snan = w_a_nan && !i_op_a[22];
        w_b_snan = w_b_nan && !i_op_b[22];

        w_special     = 1'b1;
        w_spec_result = CANON_NAN;
        w_spec_flags  = 5'b0;
        if (w_a_snan || w_b_snan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_flags[FF_NV] = 1'b1;
        end else if (w_a_nan || w_b_nan) begin
            w_spec_result = CANON_NAN;
        end else if (w_b_zero) begin
            w_spec_result       = {w_sign, 8'hFF, 23'h0};
            w_spec_flags[FF_DZ] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_result = {w_sign, 8'hFF, 23'h0};
        end else if (w_a_zero || w_b_inf) begin
            w_spec_result = {w_sign, 31'h0};
        end else begin
            w_special = 1'b0;
        end
    end

    // Quotient of two [1,2) significands lies in (0.5,2); q[26] tells which half.
    always_comb begin
        if (r_q[26]) begin
            w_sig = r_q[26:3];
            w_g   = r_q[2];
            w_s   = |r_q[1:0];
            w_exp = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + $signed(10'(EXP_BIAS));
        end else begin
            w_sig = r_q[25:2];
            w_g   = r_q[1];
            w_s   = r_q[0];
            w_exp = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + $signed(10'(EXP_BIAS - 1));
        end
    end

    fdiv_round u_round (
        .i_sign   (r_sign),
        .i_sig    (w_sig),
        .i_g      (w_g),
        .i_s      (w_s),
        .i_exp    (w_exp),
        .i_rm     (r_rm),
        .o_result (w_rnd_result),
        .o_fflags (w_rnd_flags)
    );

    // The divider free-runs, so the first done pulse after launch may belong to
    // stale inputs; SKIP drops it and WAIT takes the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_result       <= 32'h0;
            r_fflags       <= 5'h0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_q            <= '0;
            r_sign         <= 1'b0;
            r_ea           <= 8'h0;
            r_eb           <= 8'h0;
            r_rm           <= 3'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_special) begin
                            r_result    <= w_spec_result;
                            r_fflags    <= w_spec_flags;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sign         <= w_sign;
                            r_ea           <= i_op_a[30:23];
                            r_eb           <= i_op_b[30:23];
                            r_rm           <= i_rm;
                            r_div_dividend <= {1'b1, i_op_a[22:0], 3'b000};
                            r_div_divisor  <= {1'b1, i_op_b[22:0], 3'b000};
                            r_state        <= ST_SKIP;
                        end
                    end
                end
                ST_SKIP: begin
                    if (i_div_valid) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_div_valid) begin
                        r_q     <= i_div_quotient[DIV_WIDTH-1:0];
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_result    <= w_rnd_result;
                    r_fflags    <= w_rnd_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_result       = r_result;
    assign o_fflags       = r_fflags;
    assign o_div_dividend = r_div_dividend;
    assign o_div_divisor  = r_div_divisor;

endmodule
